// File: rtl/serial2parallel_gen_if.sv
// Serial ingress / parallel egress bundle for serial2parallel_gen.
// The deserialiser takes the slave side; the feeding/consuming logic takes the master side.
interface serial2parallel_gen_if #(
  parameter int DATA_W = 8
);
  logic              din_serial;
  logic              din_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_parallel;
  logic              dout_valid;
  logic              busy;
  logic              overflow;
  logic              par_err;
  logic              frame_abort;

  modport master (
    output din_serial, din_valid, dout_ready,
    input  dout_parallel, dout_valid, busy, overflow, par_err, frame_abort
  );

  modport slave (
    input  din_serial, din_valid, dout_ready,
    output dout_parallel, dout_valid, busy, overflow, par_err, frame_abort
  );
endinterface

// File: rtl/serial2parallel_gen.sv
// Parametrised serial-to-parallel deserialiser with bit-order select, optional parity,
// inter-bit gap tolerance and a valid/ready output register with overflow reporting.
module serial2parallel_gen #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_MAX    = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial2parallel_gen_if.slave  bus
);

  localparam int N     = DATA_W + PARITY_EN;
  localparam int CNT_W = $clog2(N);
  localparam int GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic              abort_q, abort_d;

  logic              data_bit_c;
  logic              last_bit_c;
  logic              complete_c;
  logic              word_ok_c;
  logic [DATA_W-1:0] word_c;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    if (MSB_FIRST != 0) return {cur[DATA_W-2:0], b};
    else                return {b, cur[DATA_W-1:1]};
  endfunction

  function automatic logic parity_ok(input logic [DATA_W-1:0] w, input logic p);
    return ((^w) ^ p) == (PARITY_ODD != 0);
  endfunction

  // The parity bit occupies the slot after the data bits and never shifts into the word.
  assign data_bit_c = (int'(cnt_q) < DATA_W);
  assign last_bit_c = (int'(cnt_q) == N - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    sh_d       = sh_q;
    dout_d     = dout_q;
    dv_d       = dv_q;
    ovf_d      = 1'b0;
    perr_d     = 1'b0;
    abort_d    = 1'b0;
    complete_c = 1'b0;
    word_ok_c  = 1'b0;
    word_c     = sh_q;

    if (bus.din_valid) begin
      gap_d = '0;
      if (data_bit_c) sh_d = shift_in(sh_q, bus.din_serial);
      if (last_bit_c) begin
        complete_c = 1'b1;
        cnt_d      = '0;
        state_d    = ST_IDLE;
        if (PARITY_EN != 0) begin
          word_c    = sh_q;
          word_ok_c = parity_ok(sh_q, bus.din_serial);
        end else begin
          word_c    = sh_d;
          word_ok_c = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_SHIFT;
      end
    end else if (state_q == ST_SHIFT) begin
      if (gap_q == GAP_W'(GAP_MAX)) begin
        cnt_d   = '0;
        gap_d   = '0;
        state_d = ST_IDLE;
        abort_d = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    // A full register may be refilled only when its word is consumed on the same edge.
    if (complete_c && word_ok_c) begin
      if (!dv_q || bus.dout_ready) begin
        dout_d = word_c;
        dv_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      perr_d = complete_c;
      if (dv_q && bus.dout_ready) dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
    end
  end

  assign bus.dout_parallel = dout_q;
  assign bus.dout_valid    = dv_q;
  assign bus.busy          = (cnt_q != '0);
  assign bus.overflow      = ovf_q;
  assign bus.par_err       = perr_q;
  assign bus.frame_abort   = abort_q;

endmodule
